timing_decode: RTL and testbench
================================

Name: timing_decode

Overview:
- Timing generator and opcode decoder for the accumulator CPU.
- Sits directly upstream of the control-signal unit and supplies its one-hot beat strobes T0..T7 and decoded opcode lines LD, ADD, SUB, AND, OR, STO, HALT.
- Sequences the fetch/execute beat ring, shortens the ring per instruction, and stops the machine on HALT or an illegal opcode.

Parameters:
- IR_W, 8, instruction register width.
- OP_W, 3, opcode field width; opcode = ir[IR_W-1 -: OP_W].
- AUTO_START, 1: 1 = leave reset in RUN at T0; 0 = leave reset in HALTED.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; leaves HALTED.
- step_en  input  1  beat advance enable; low = freeze current beat.
- ir  input  IR_W  instruction register contents; valid from T3 onward.
- T0..T7  output  1 each  one-hot beat strobes, registered.
- LD, ADD, SUB, AND, OR, STO, HALT  output  1 each  decoded opcode lines.
- running  output  1  high in RUN state.
- illegal  output  1  sticky flag: an illegal opcode halted the machine.

Behaviour:
- Reset is asynchronous, active-low, on rst_n.
  - AUTO_START=1: state RUN, T0=1, T1..T7=0, running=1, illegal=0.
  - AUTO_START=0: state HALTED, all T=0, running=0, illegal=0.
- States:
  - RUN: exactly one T high.
  - HALTED: all T low and running=0.
- Advance in RUN happens only on a clk edge with step_en=1. With step_en=0, beat, state and flags hold.
- Normal ring is T0→T1→…→T7→T0.
- Opcode map: 000 LD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 STO, 110 HALT, 111 illegal.
- Decode outputs are combinational from ir and gated: each is high only while state is RUN and one of T3..T7 is high. All decode outputs are 0 during T0..T2 and in HALTED. At most one decode line is high at a time.
- Ring shortening:
  - LD: T6→T0, so T7 is skipped.
  - ADD/SUB/AND/OR/STO: full ring through T7.
  - HALT: at the advancing edge in T5, go to HALTED. T5 is the last beat, so the T5 PC increment still occurs.
  - Illegal (111): at the advancing edge in T3, go to HALTED and set illegal=1.
- start:
  - In HALTED: on the next clk edge go to RUN at T0 and clear illegal. step_en is not required.
  - In RUN: ignored.
- start coincident with the HALT/illegal transition edge: the halt wins. start must be reasserted later.
- Asserting reset mid-instruction aborts immediately to the reset state. No partial beat completes.
- Illegal or non-one-hot phase encodings must be unreachable. Internal phase register is one-hot with a T0 recovery default.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_LD..OP_HALT, OP_ILL;
  - phase index constants PH_T0..PH_T7;
  - state enum {ST_HALTED, ST_RUN}.
- One natural sub-module: opcode_dec. It is the combinational opcode→one-hot decode with a gating input; it is reused by the disassembler/monitor.
- The ring/state FSM stays in timing_decode.

Test Plan:
- Reset with AUTO_START=1, step_en=1, ir=8'b001_00000 (ADD):
  - T0..T7 each pulse exactly one cycle in order, then T0 recurs.
  - ADD is high only during the 5 cycles T3..T7.
- ir=8'b000_00000 (LD):
  - sequence is T0..T6 then T0; T7 never asserts.
  - LD is high during T3..T6.
- ir=8'b110_00000 (HALT):
  - after T5, all T=0 and running=0; outputs stay static for 20 cycles.
  - a start pulse gives T0=1 on the next cycle.
- ir=8'b111_00000:
  - after T3, machine is HALTED and illegal=1, with no decode line ever high.
  - start clears illegal and restarts at T0.
- step_en low for 3 cycles during T4 (ir=STO): T4 and STO hold for 4 total cycles, then T5 follows.
- rst_n pulled low mid-T6 of ADD: outputs go to reset values asynchronously, before the next clk edge. After release, T0 is high on the first cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode map, beat indices,
// machine state and the decoded-opcode bundle.
package cpu_pkg;

    localparam int NUM_PH = 8;

    localparam logic [2:0] OP_LD   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_STO  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam int PH_T0 = 0;
    localparam int PH_T1 = 1;
    localparam int PH_T2 = 2;
    localparam int PH_T3 = 3;
    localparam int PH_T4 = 4;
    localparam int PH_T5 = 5;
    localparam int PH_T6 = 6;
    localparam int PH_T7 = 7;

    typedef enum logic {
        ST_HALTED = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    typedef struct packed {
        logic halt;
        logic sto;
        logic or_l;
        logic and_l;
        logic sub;
        logic add;
        logic ld;
    } dec_t;

    // One-hot phase vector with only the bit for beat 'idx' set.
    function automatic logic [NUM_PH-1:0] ph_bit(input int idx);
        ph_bit = NUM_PH'(1) << idx;
    endfunction

endpackage

// File: rtl/timing_decode_if.sv
// Control/status bundle between the timing/decode block and its user:
// start/step/IR in, beat strobes, decoded opcode lines and status out.
interface timing_decode_if #(
    parameter int IR_W = 8
);
    logic            start;
    logic            step_en;
    logic [IR_W-1:0] ir;

    logic T0, T1, T2, T3, T4, T5, T6, T7;
    logic LD, ADD, SUB, AND, OR, STO, HALT;
    logic running;
    logic illegal;

    modport master (
        output start, step_en, ir,
        input  T0, T1, T2, T3, T4, T5, T6, T7,
        input  LD, ADD, SUB, AND, OR, STO, HALT,
        input  running, illegal
    );

    modport slave (
        input  start, step_en, ir,
        output T0, T1, T2, T3, T4, T5, T6, T7,
        output LD, ADD, SUB, AND, OR, STO, HALT,
        output running, illegal
    );

endinterface

// File: rtl/opcode_dec.sv
// Combinational opcode to one-hot decode with an enable gate. The illegal
// opcode decodes to no line at all. Also used by the disassembler/monitor.
module opcode_dec
    import cpu_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [OP_W-1:0] opcode,
    input  logic            en,
    output dec_t            dec
);

    // Raise exactly one line for a legal opcode while the gate is open
    always_comb begin
        dec = '0;
        if (en) begin
            case (opcode)
                OP_W'(OP_LD):   dec.ld    = 1'b1;
                OP_W'(OP_ADD):  dec.add   = 1'b1;
                OP_W'(OP_SUB):  dec.sub   = 1'b1;
                OP_W'(OP_AND):  dec.and_l = 1'b1;
                OP_W'(OP_OR):   dec.or_l  = 1'b1;
                OP_W'(OP_STO):  dec.sto   = 1'b1;
                OP_W'(OP_HALT): dec.halt  = 1'b1;
                default:        dec       = '0;
            endcase
        end
    end

endmodule

// File: rtl/timing_decode.sv
// Beat-ring timing generator and gated opcode decoder. Runs the T0..T7 ring,
// shortens it for LD, stops after T5 for HALT and after T3 for an illegal
// opcode (leaving the sticky illegal flag set).
module timing_decode
    import cpu_pkg::*;
#(
    parameter int IR_W       = 8,
    parameter int OP_W       = 3,
    parameter bit AUTO_START = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    timing_decode_if.slave bus
);

    state_e              state_q, state_d;
    logic [NUM_PH-1:0]   phase_q, phase_d;
    logic [NUM_PH-1:0]   t_q, t_d;
    logic                running_q, running_d;
    logic                illegal_q, illegal_d;

    logic [OP_W-1:0]     opcode;
    logic                is_ld, is_halt, is_ill;
    logic                halt_now, ill_now;
    logic [NUM_PH-1:0]   phase_next;
    logic                dec_en;
    dec_t                dec;
    logic                unused_ir;

    assign opcode    = bus.ir[IR_W-1 -: OP_W];
    assign unused_ir = ^bus.ir[IR_W-OP_W-1:0];

    assign is_ld   = (opcode == OP_W'(OP_LD));
    assign is_halt = (opcode == OP_W'(OP_HALT));
    assign is_ill  = (opcode == OP_W'(OP_ILL));

    assign halt_now = phase_q[PH_T5] & is_halt;
    assign ill_now  = phase_q[PH_T3] & is_ill;

    // Successor beat on the ring; LD wraps from T6, any corrupt phase recovers to T0
    always_comb begin
        phase_next = ph_bit(PH_T0);
        case (phase_q)
            ph_bit(PH_T0): phase_next = ph_bit(PH_T1);
            ph_bit(PH_T1): phase_next = ph_bit(PH_T2);
            ph_bit(PH_T2): phase_next = ph_bit(PH_T3);
            ph_bit(PH_T3): phase_next = ph_bit(PH_T4);
            ph_bit(PH_T4): phase_next = ph_bit(PH_T5);
            ph_bit(PH_T5): phase_next = ph_bit(PH_T6);
            ph_bit(PH_T6): phase_next = is_ld ? ph_bit(PH_T0) : ph_bit(PH_T7);
            ph_bit(PH_T7): phase_next = ph_bit(PH_T0);
            default:       phase_next = ph_bit(PH_T0);
        endcase
    end

    // Run/halt state machine; halting wins over a coincident start because start is only seen in HALTED
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_HALTED: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    phase_d   = ph_bit(PH_T0);
                    illegal_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus.step_en) begin
                    if (ill_now) begin
                        state_d   = ST_HALTED;
                        phase_d   = ph_bit(PH_T0);
                        illegal_d = 1'b1;
                    end else if (halt_now) begin
                        state_d   = ST_HALTED;
                        phase_d   = ph_bit(PH_T0);
                    end else begin
                        phase_d   = phase_next;
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
                phase_d = ph_bit(PH_T0);
            end
        endcase
        running_d = (state_d == ST_RUN);
        t_d       = running_d ? phase_d : '0;
    end

    // State, phase and registered output strobes; reset lands in RUN/T0 or HALTED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= AUTO_START ? ST_RUN : ST_HALTED;
            phase_q   <= ph_bit(PH_T0);
            t_q       <= AUTO_START ? ph_bit(PH_T0) : '0;
            running_q <= AUTO_START;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            t_q       <= t_d;
            running_q <= running_d;
            illegal_q <= illegal_d;
        end
    end

    assign dec_en = running_q & (|t_q[PH_T7:PH_T3]);

    opcode_dec #(
        .OP_W (OP_W)
    ) u_dec (
        .opcode (opcode),
        .en     (dec_en),
        .dec    (dec)
    );

    assign bus.T0 = t_q[PH_T0];
    assign bus.T1 = t_q[PH_T1];
    assign bus.T2 = t_q[PH_T2];
    assign bus.T3 = t_q[PH_T3];
    assign bus.T4 = t_q[PH_T4];
    assign bus.T5 = t_q[PH_T5];
    assign bus.T6 = t_q[PH_T6];
    assign bus.T7 = t_q[PH_T7];

    assign bus.LD   = dec.ld;
    assign bus.ADD  = dec.add;
    assign bus.SUB  = dec.sub;
    assign bus.AND  = dec.and_l;
    assign bus.OR   = dec.or_l;
    assign bus.STO  = dec.sto;
    assign bus.HALT = dec.halt;

    assign bus.running = running_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_timing_decode.sv
// Self-checking bench for timing_decode: directed scenarios followed by
// randomized stimulus, all compared against an instruction-level model.
module tb_timing_decode;

    logic clk;
    logic rst_n;

    timing_decode_if #(.IR_W(8)) bus ();

    timing_decode #(
        .IR_W       (8),
        .OP_W       (3),
        .AUTO_START (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: is the machine running, which beat is it on, illegal flag
    bit         mRun;
    int         mBeat;
    bit         mIll;
    logic [7:0] curIr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRun  = 1'b1;
        mBeat = 0;
        mIll  = 1'b0;
    endtask

    // Instruction length: HALT ends after beat 5, LD after beat 6, others after beat 7
    task automatic modelStep(input logic s, input logic se, input logic [7:0] irv);
        int op;
        int lastBeat;
        op = int'(irv[7:5]);
        lastBeat = (op == 6) ? 5 : ((op == 0) ? 6 : 7);
        if (!mRun) begin
            if (s) begin
                mRun  = 1'b1;
                mBeat = 0;
                mIll  = 1'b0;
            end
        end else if (se) begin
            if (op == 7 && mBeat == 3) begin
                mRun = 1'b0;
                mIll = 1'b1;
            end else if (mBeat == lastBeat) begin
                if (op == 6) mRun = 1'b0;
                else         mBeat = 0;
            end else begin
                mBeat = mBeat + 1;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        logic [7:0] expT;
        logic [6:0] expDec;
        logic [7:0] obsT;
        logic [6:0] obsDec;
        int op;
        op     = int'(curIr[7:5]);
        expT   = mRun ? (8'd1 << mBeat) : 8'd0;
        expDec = (mRun && mBeat >= 3 && op != 7) ? (7'd1 << op) : 7'd0;
        obsT   = {bus.T7, bus.T6, bus.T5, bus.T4, bus.T3, bus.T2, bus.T1, bus.T0};
        obsDec = {bus.HALT, bus.STO, bus.OR, bus.AND, bus.SUB, bus.ADD, bus.LD};
        checkOutput({tag, ".beats"},   32'(obsT),        32'(expT));
        checkOutput({tag, ".decode"},  32'(obsDec),      32'(expDec));
        checkOutput({tag, ".running"}, 32'(bus.running), 32'(mRun));
        checkOutput({tag, ".illegal"}, 32'(bus.illegal), 32'(mIll));
    endtask

    // Check the current outputs, drive one cycle of inputs, advance model; ends on a falling edge
    task automatic applyStimulus(input string tag, input logic s, input logic se, input logic [7:0] irv);
        checkAll(tag);
        bus.start   = s;
        bus.step_en = se;
        bus.ir      = irv;
        curIr       = irv;
        @(posedge clk);
        modelStep(s, se, irv);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before the next rising edge
    task automatic doReset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll({tag, ".async"});
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.step_en = 1'b0;
        bus.ir      = 8'h00;
        curIr       = 8'h00;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkAll("reset");

        for (int i = 0; i < 10; i++) applyStimulus("add", 1'b0, 1'b1, 8'b001_00000);

        doReset("pre_ld");
        for (int i = 0; i < 10; i++) applyStimulus("ld", 1'b0, 1'b1, 8'b000_00000);

        doReset("pre_halt");
        for (int i = 0; i < 6; i++) applyStimulus("halt", 1'b0, 1'b1, 8'b110_00000);
        for (int i = 0; i < 20; i++) applyStimulus("halted", 1'b0, 1'($urandom), 8'b110_00000);
        applyStimulus("halt_start", 1'b1, 1'b0, 8'b001_00000);
        for (int i = 0; i < 3; i++) applyStimulus("halt_resume", 1'b0, 1'b1, 8'b001_00000);

        doReset("pre_ill");
        for (int i = 0; i < 4; i++) applyStimulus("ill", 1'b0, 1'b1, 8'b111_00000);
        for (int i = 0; i < 5; i++) applyStimulus("ill_hold", 1'b0, 1'b1, 8'b111_00000);
        applyStimulus("ill_start", 1'b1, 1'b1, 8'b010_00000);
        for (int i = 0; i < 4; i++) applyStimulus("ill_resume", 1'b0, 1'b1, 8'b010_00000);

        doReset("pre_sto");
        for (int i = 0; i < 4; i++) applyStimulus("sto_run", 1'b0, 1'b1, 8'b101_00000);
        for (int i = 0; i < 3; i++) applyStimulus("sto_freeze", 1'b0, 1'b0, 8'b101_00000);
        for (int i = 0; i < 3; i++) applyStimulus("sto_go", 1'b0, 1'b1, 8'b101_00000);

        doReset("pre_abort");
        for (int i = 0; i < 6; i++) applyStimulus("abort_run", 1'b0, 1'b1, 8'b001_00000);
        doReset("abort_t6");
        applyStimulus("after_abort", 1'b0, 1'b1, 8'b001_00000);

        // Random instruction mix, step gaps, stray starts and occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] irv;
            logic       s;
            logic       se;
            int         r;
            irv = curIr;
            if (!mRun || mBeat < 3) begin
                if ($urandom_range(0, 3) == 0 || !mRun) begin
                    r = int'($urandom_range(0, 15));
                    irv[7:5] = (r < 12) ? 3'(r % 6) : ((r < 14) ? 3'd6 : 3'd7);
                    irv[4:0] = 5'($urandom);
                end
            end
            se = ($urandom_range(0, 3) != 0);
            s  = mRun ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) doReset("rand_rst");
            applyStimulus("rand", s, se, irv);
        end
        checkAll("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
